// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - debounced three-button hours/minutes/seconds time-set controller
module time_set_ctrl #(
    parameter int DB_CYCLES     = 50000,
    parameter int REPEAT_CYCLES = 25000000,
    parameter int HR24          = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       b_mode_i,
    input  logic       b_up_i,
    input  logic       b_down_i,
    input  logic [5:0] cur_hrs_i,
    input  logic [5:0] cur_min_i,
    input  logic [5:0] cur_sec_i,
    output logic       set_time,
    output logic [5:0] set_hrs,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       edit_active,
    output logic [1:0] field_sel
);

    localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RPW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
    localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_CYCLES - 1);
    localparam logic [5:0] HR_MAX = (HR24 != 0) ? 6'd23 : 6'd12;
    localparam logic [5:0] HR_MIN = (HR24 != 0) ? 6'd0 : 6'd1;
    localparam logic [5:0] HR_RST = (HR24 != 0) ? 6'd0 : 6'd12;
    localparam logic [5:0] MS_MAX = 6'd59;

    typedef enum logic [2:0] {
        IDLE,
        EDIT_HRS,
        EDIT_MIN,
        EDIT_SEC,
        COMMIT
    } state_t;

    state_t state, state_next;

    // Button index: 0 mode, 1 up, 2 down.
    logic [2:0]     raw;
    logic [2:0]     sync1, sync2, level, db_pulse;
    logic [DBW-1:0] db_cnt [3];
    logic [RPW-1:0] rp_cnt [2];
    logic [1:0]     rp_pulse;
    logic           mode_p, up_p, down_p;

    assign raw = {b_down_i, b_up_i, b_mode_i};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1    <= '0;
            sync2    <= '0;
            level    <= '0;
            db_pulse <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                db_pulse[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]    <= sync2[i];
                    db_cnt[i]   <= '0;
                    db_pulse[i] <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Hold counters start on the cycle the debounced level rises, so the
    // first repeat lands one full period after the initial press.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rp_pulse <= '0;
            for (int j = 0; j < 2; j++) rp_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                rp_pulse[j] <= 1'b0;
                if (!level[j+1]) begin
                    rp_cnt[j] <= '0;
                end else if (rp_cnt[j] == RP_LAST) begin
                    rp_cnt[j]   <= '0;
                    rp_pulse[j] <= 1'b1;
                end else begin
                    rp_cnt[j] <= rp_cnt[j] + 1'b1;
                end
            end
        end
    end

    assign mode_p = db_pulse[0];
    assign up_p   = db_pulse[1] | rp_pulse[0];
    assign down_p = db_pulse[2] | rp_pulse[1];

    function automatic logic [5:0] step(input logic [5:0] v, input logic [5:0] lo,
                                        input logic [5:0] hi, input logic inc);
        if (inc) return (v == hi) ? lo : v + 6'd1;
        else     return (v == lo) ? hi : v - 6'd1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        set_time    = 1'b0;
        edit_active = 1'b0;
        field_sel   = 2'b00;
        case (state)
            IDLE:     if (mode_p) state_next = EDIT_HRS;
            EDIT_HRS: begin
                edit_active = 1'b1;
                field_sel   = 2'b01;
                if (mode_p) state_next = EDIT_MIN;
            end
            EDIT_MIN: begin
                edit_active = 1'b1;
                field_sel   = 2'b10;
                if (mode_p) state_next = EDIT_SEC;
            end
            EDIT_SEC: begin
                edit_active = 1'b1;
                field_sel   = 2'b11;
                if (mode_p) state_next = COMMIT;
            end
            COMMIT: begin
                set_time   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Mode has priority; opposing up and down in one cycle cancel out.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            set_hrs <= HR_RST;
            set_min <= 6'd0;
            set_sec <= 6'd0;
        end else if (state == IDLE && mode_p) begin
            set_hrs <= (cur_hrs_i > HR_MAX || cur_hrs_i < HR_MIN) ? HR_MAX : cur_hrs_i;
            set_min <= (cur_min_i > MS_MAX) ? MS_MAX : cur_min_i;
            set_sec <= (cur_sec_i > MS_MAX) ? MS_MAX : cur_sec_i;
        end else if (!mode_p && (up_p ^ down_p)) begin
            case (state)
                EDIT_HRS: set_hrs <= step(set_hrs, HR_MIN, HR_MAX, up_p);
                EDIT_MIN: set_min <= step(set_min, 6'd0, MS_MAX, up_p);
                EDIT_SEC: set_sec <= step(set_sec, 6'd0, MS_MAX, up_p);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - scoreboard bench for time_set_ctrl in 24 h and 12 h builds
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [2:0] b24 = 3'b000;
    logic [2:0] b12 = 3'b000;
    logic [5:0] cur_hrs = 6'd0, cur_min = 6'd0, cur_sec = 6'd0;

    logic       st24, ea24, st12, ea12;
    logic [5:0] h24, m24, s24, h12, m12, s12;
    logic [1:0] fs24, fs12;

    int n_pass = 0;
    int n_chk = 0;
    int n_commit = 0;
    int sb_q[$];

    always #5 clk = ~clk;

    time_set_ctrl #(.DB_CYCLES(4), .REPEAT_CYCLES(16), .HR24(1)) dut24 (
        .clk_i(clk), .reset_i(reset_i),
        .b_mode_i(b24[0]), .b_up_i(b24[1]), .b_down_i(b24[2]),
        .cur_hrs_i(cur_hrs), .cur_min_i(cur_min), .cur_sec_i(cur_sec),
        .set_time(st24), .set_hrs(h24), .set_min(m24), .set_sec(s24),
        .edit_active(ea24), .field_sel(fs24)
    );

    time_set_ctrl #(.DB_CYCLES(4), .REPEAT_CYCLES(16), .HR24(0)) dut12 (
        .clk_i(clk), .reset_i(reset_i),
        .b_mode_i(b12[0]), .b_up_i(b12[1]), .b_down_i(b12[2]),
        .cur_hrs_i(cur_hrs), .cur_min_i(cur_min), .cur_sec_i(cur_sec),
        .set_time(st12), .set_hrs(h12), .set_min(m12), .set_sec(s12),
        .edit_active(ea12), .field_sel(fs12)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int hms(input int h, input int m, input int s);
        return h * 4096 + m * 64 + s;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press24(input logic [2:0] mask);
        b24 = mask;
        cyc(8);
        b24 = 3'b000;
        cyc(10);
    endtask

    task automatic press12(input logic [2:0] mask);
        b12 = mask;
        cyc(8);
        b12 = 3'b000;
        cyc(10);
    endtask

    always @(negedge clk) begin
        if (st24) begin
            n_commit++;
            if (sb_q.size() == 0) check("sb_unexpected_set_time", 1, 0);
            else check("sb_set_value", int'({h24, m24, s24}), sb_q.pop_front());
        end
    end

    initial begin
        bit seen;
        cyc(3);
        check("rst_field", int'(fs24), 0);
        check("rst_edit", int'(ea24), 0);
        check("rst_set_time", int'(st24), 0);
        check("rst_val24", int'({h24, m24, s24}), hms(0, 0, 0));
        check("rst_hrs12", int'(h12), 12);
        reset_i = 1'b0;
        cyc(2);

        // Plain walk through all fields
        cur_hrs = 6'd23; cur_min = 6'd59; cur_sec = 6'd58;
        press24(3'b001);
        check("walk_f1", int'(fs24), 1);
        check("walk_edit", int'(ea24), 1);
        check("walk_capture", int'({h24, m24, s24}), hms(23, 59, 58));
        press24(3'b001);
        check("walk_f2", int'(fs24), 2);
        press24(3'b001);
        check("walk_f3", int'(fs24), 3);
        sb_q.push_back(hms(23, 59, 58));
        press24(3'b001);
        check("walk_f0", int'(fs24), 0);
        check("walk_idle_edit", int'(ea24), 0);

        // One up in each field, all wrapping except seconds
        press24(3'b001);
        press24(3'b010);
        check("up_hrs_wrap", int'(h24), 0);
        press24(3'b001);
        press24(3'b010);
        check("up_min_wrap", int'(m24), 0);
        press24(3'b001);
        press24(3'b010);
        check("up_sec", int'(s24), 59);
        sb_q.push_back(hms(0, 0, 59));
        press24(3'b001);

        // Out-of-range capture clamps
        cur_hrs = 6'd30; cur_min = 6'd61; cur_sec = 6'd60;
        press24(3'b001);
        check("clamp", int'({h24, m24, s24}), hms(23, 59, 59));
        press24(3'b100);
        check("down_hrs", int'(h24), 22);
        press24(3'b001);
        press24(3'b001);
        sb_q.push_back(hms(22, 59, 59));
        press24(3'b001);

        // Auto-repeat in EDIT_MIN from 57
        cur_hrs = 6'd10; cur_min = 6'd57; cur_sec = 6'd0;
        press24(3'b001);
        press24(3'b001);
        check("rep_field", int'(fs24), 2);
        b24 = 3'b010;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(1);
            if (m24 == 6'd58) seen = 1'b1;
        end
        check("rep_first_press", int'(seen), 1);
        cyc(44);
        b24 = 3'b000;
        cyc(30);
        check("rep_three_repeats", int'(m24), 1);

        // Short glitch, opposing presses, mode with up
        b24 = 3'b010;
        cyc(3);
        b24 = 3'b000;
        cyc(12);
        check("glitch_nochange", int'(m24), 1);
        press24(3'b110);
        check("updown_nochange", int'(m24), 1);
        press24(3'b011);
        check("modeup_advance", int'(fs24), 3);
        check("modeup_value", int'({h24, m24, s24}), hms(10, 1, 0));
        sb_q.push_back(hms(10, 1, 0));
        press24(3'b001);

        // Reset in the middle of an edit
        cur_hrs = 6'd5; cur_min = 6'd6; cur_sec = 6'd7;
        press24(3'b001);
        press24(3'b001);
        check("mid_field", int'(fs24), 2);
        check("mid_hrs", int'(h24), 5);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_field", int'(fs24), 0);
        check("rstmid_edit", int'(ea24), 0);
        check("rstmid_set_time", int'(st24), 0);
        check("rstmid_val", int'({h24, m24, s24}), hms(0, 0, 0));
        @(negedge clk);
        reset_i = 1'b0;
        cyc(2);

        // 12 h hours wrap
        cur_hrs = 6'd1; cur_min = 6'd0; cur_sec = 6'd0;
        press12(3'b001);
        check("h12_field", int'(fs12), 1);
        check("h12_capture", int'(h12), 1);
        press12(3'b100);
        check("h12_down_wrap", int'(h12), 12);
        press12(3'b010);
        check("h12_up_wrap", int'(h12), 1);
        cur_hrs = 6'd0;
        press12(3'b001);
        press12(3'b001);
        press12(3'b001);
        press12(3'b001);
        check("h12_clamp_zero", int'(h12), 12);
        check("h12_set_time_idle", int'(st12), 0);

        cyc(5);
        check("sb_drained", sb_q.size(), 0);
        check("commit_count", n_commit, 4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
